sram_arbiter_ctrl: RTL and testbench
====================================

# sram_arbiter_ctrl

Two-port, round-robin arbitrated controller for a single IHP_SRAM_1024x32 macro instance in the fabric user-design area. It accepts word read/write commands from two requesters (A, B) over a REQ/GNT handshake, sequences the macro's MEN/WEN/REN strobes, and expands per-byte enables into the macro's per-bit mask. It returns registered read data per port. Requesters never touch the macro pins directly.

## Interface
Parameters:
- ADDR_W, 10, word address width; matches the 1024-entry macro.
- DATA_W, 32, data width; must be 32, with 4 byte lanes.

Ports:
- CLK  in  1  single clock for the block and the macro.
- RST  in  1  synchronous, active-high reset.
- A_REQ  in  1  port A command request; held with its payload until granted.
- A_WE  in  1  1 = write, 0 = read.
- A_ADDR  in  ADDR_W  word address.
- A_BE  in  4  byte enables for writes; ignored on reads.
- A_WDATA  in  DATA_W  write data.
- A_GNT  out  1  command accepted this cycle; combinational, asserted only in IDLE.
- A_RVALID  out  1  one-cycle pulse; A_RDATA is valid in this cycle.
- A_RDATA  out  DATA_W  registered read data; held until the next A read completes.
- B_*  same set as A_*, for port B.
- SRAM_ADDR  out  ADDR_W  to macro ADDR.
- SRAM_BM  out  DATA_W  to macro BM; active-high per-bit write mask.
- SRAM_DIN  out  DATA_W  to macro DIN.
- SRAM_MEN, SRAM_WEN, SRAM_REN  out  1 each  macro strobes, active-high.
- SRAM_DOUT  in  DATA_W  from macro DOUT; valid in the cycle after a read strobe.

## Operation
- FSM states: IDLE, CMD, RWAIT.
- IDLE:
  - If any REQ is high, grant exactly one port.
  - Latch that port's WE/ADDR/BE/WDATA and the grant owner.
  - Go to CMD.
- CMD:
  - Registered outputs are MEN=1, REN=~WE, WEN=WE, ADDR=latched address.
  - Write: BM[8i+7:8i] = {8{BE[i]}}, DIN = WDATA.
  - Read: BM = 0, DIN = 0.
  - Next state: read → RWAIT; write → IDLE.
- RWAIT:
  - Strobes low.
  - Capture SRAM_DOUT into the owner's RDATA register.
  - Set the owner's RVALID for the next cycle.
  - Go to IDLE.
- Arbitration:
  - A one-bit priority pointer selects the preferred port; reset value is A.
  - On simultaneous requests, the pointer's port wins.
  - After every grant the pointer moves to the non-granted port.
  - A lone request is granted regardless of the pointer.
- A write with BE=0 still runs a full cycle (MEN=1, WEN=1, BM=0); the memory is unchanged.
- REQ is not sampled outside IDLE; GNT is 0 in CMD and RWAIT.

## Timing
- Reset values:
  - State IDLE, pointer A.
  - All GNT and RVALID = 0.
  - MEN/WEN/REN = 0.
  - SRAM_ADDR/BM/DIN = 0; A_RDATA and B_RDATA = 0.
- Read: GNT in cycle t → strobes in t+1 → DOUT captured at the end of t+2 → RVALID in t+3.
- Write: GNT in t → strobes in t+1 → next GNT possible in t+2.
- Throughput: one write per 2 cycles, one read per 3 cycles. A new GNT may coincide with a previous RVALID cycle.
- Strobes are high for exactly one cycle per command.
- SRAM_ADDR/BM/DIN hold their last values while idle.
- Reset mid-operation: strobes are 0 the cycle after RST is seen. A pending read is discarded with no RVALID, and the pointer returns to A.
- RVALID for A and B are never high in the same cycle.

## Test plan
- Reset, then write A_ADDR=0x3FF, WDATA=0xDEADBEEF, BE=4'hF; read it back on port A → A_RVALID pulse in t+3 with A_RDATA=0xDEADBEEF; B_RVALID stays 0.
- Word holds 0x00000000; write via B with BE=4'b0101, WDATA=0xAABBCCDD → SRAM_BM=0x00FF00FF during CMD; readback = 0x00BB00DD.
- A and B request reads at addresses 0x001 and 0x002 together, continuously, from reset → grant order A,B,A,B; each RVALID goes to the matching port with the correct data.
- Write with BE=0 over a word holding 0x12345678 → MEN=1, WEN=1, BM=0 for one cycle; readback = 0x12345678.
- Assert RST in the RWAIT cycle of a port-A read → no A_RVALID; next cycle all strobes are 0, state is IDLE, and the next simultaneous request grants A.
- Back-to-back writes from A alone, REQ held → A_GNT every 2nd cycle; MEN high on alternate cycles, never two in a row.

Source files
------------

// File: rtl/sram_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// sram_arbiter_ctrl
// Round-robin arbiter and strobe sequencer that gives two requesters (A, B)
// word access to a single 1024x32 SRAM macro. Each command runs IDLE -> CMD
// (one strobe cycle) and, for reads, one extra RWAIT cycle that captures the
// macro output into the owner's read-data register.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   {a,b}_req_i             command request, payload held until granted
//   {a,b}_we_i              1 = write, 0 = read
//   {a,b}_addr_i            word address
//   {a,b}_be_i              byte enables (writes only)
//   {a,b}_wdata_i           write data
//   {a,b}_gnt_o             command accepted this cycle (IDLE only)
//   {a,b}_rvalid_o          one-cycle pulse, rdata valid
//   {a,b}_rdata_o           registered read data, held until next read
//   sram_addr_o/bm_o/din_o  macro address, per-bit write mask, write data
//   sram_men_o/wen_o/ren_o  macro strobes, active-high
//   sram_dout_i             macro read data, valid the cycle after REN
//
// state | meaning
// IDLE  | waiting for a request; grant is issued here
// CMD   | macro strobes asserted for the latched command
// RWAIT | macro output valid; capture into the owner's rdata register
// ---------------------------------------------------------------------------
module sram_arbiter_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [3:0]        a_be_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_gnt_o,
  output logic              a_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,

  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [3:0]        b_be_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_gnt_o,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] b_rdata_o,

  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_bm_o,
  output logic [DATA_W-1:0] sram_din_o,
  output logic              sram_men_o,
  output logic              sram_wen_o,
  output logic              sram_ren_o,
  input  logic [DATA_W-1:0] sram_dout_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RWAIT = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   ptr_q, ptr_d;       // preferred port on a tie: 0 = A, 1 = B
  logic   owner_q, owner_d;   // port that owns the command in flight
  logic   we_q, we_d;

  logic              men_q, men_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] bm_q, bm_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  // Grant selection. A lone request wins outright; a tie goes to ptr_q.
  // Grants are suppressed while reset is asserted so nothing is accepted
  // that the reset would immediately discard.
  logic              gnt_any;
  logic              gnt_sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] sel_mask;

  always_comb begin
    gnt_any   = (state_q == IDLE) && !rst_i && (a_req_i || b_req_i);
    gnt_sel   = (a_req_i && b_req_i) ? ptr_q : b_req_i;
    sel_we    = gnt_sel ? b_we_i    : a_we_i;
    sel_addr  = gnt_sel ? b_addr_i  : a_addr_i;
    sel_be    = gnt_sel ? b_be_i    : a_be_i;
    sel_wdata = gnt_sel ? b_wdata_i : a_wdata_i;
    sel_mask  = '0;
    for (int i = 0; i < 4; i++) begin
      sel_mask[8*i +: 8] = {8{sel_be[i]}};
    end
  end

  assign a_gnt_o = gnt_any && !gnt_sel;
  assign b_gnt_o = gnt_any &&  gnt_sel;

  // State register (plus all output registers)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      men_q      <= 1'b0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      addr_q     <= '0;
      bm_q       <= '0;
      din_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      men_q      <= men_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      addr_q     <= addr_d;
      bm_q       <= bm_d;
      din_q      <= din_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = CMD;
          ptr_d   = ~gnt_sel;
          owner_d = gnt_sel;
          we_d    = sel_we;
        end
      end
      CMD:     state_d = we_q ? IDLE : RWAIT;
      RWAIT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The macro-facing registers are loaded on the grant edge,
  // so they hold the latched command for exactly the CMD cycle; the address,
  // mask and data then keep their values until the next grant.
  always_comb begin
    men_d      = 1'b0;
    wen_d      = 1'b0;
    ren_d      = 1'b0;
    addr_d     = addr_q;
    bm_d       = bm_q;
    din_d      = din_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;

    if (state_q == IDLE && gnt_any) begin
      men_d  = 1'b1;
      wen_d  = sel_we;
      ren_d  = ~sel_we;
      addr_d = sel_addr;
      bm_d   = sel_we ? sel_mask  : '0;
      din_d  = sel_we ? sel_wdata : '0;
    end

    if (state_q == RWAIT) begin
      if (owner_q) begin
        b_rdata_d  = sram_dout_i;
        b_rvalid_d = 1'b1;
      end else begin
        a_rdata_d  = sram_dout_i;
        a_rvalid_d = 1'b1;
      end
    end
  end

  assign sram_men_o  = men_q;
  assign sram_wen_o  = wen_q;
  assign sram_ren_o  = ren_q;
  assign sram_addr_o = addr_q;
  assign sram_bm_o   = bm_q;
  assign sram_din_o  = din_q;
  assign a_rvalid_o  = a_rvalid_q;
  assign b_rvalid_o  = b_rvalid_q;
  assign a_rdata_o   = a_rdata_q;
  assign b_rdata_o   = b_rdata_q;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter_ctrl
// Directed bench for sram_arbiter_ctrl with a behavioural SRAM macro model
// and a read scoreboard (expected port/data pushed at grant, popped on
// RVALID).
// ---------------------------------------------------------------------------
module tb_sram_arbiter_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              a_req = 0, a_we = 0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [3:0]        a_be = '0;
  logic [DATA_W-1:0] a_wdata = '0;
  logic              b_req = 0, b_we = 0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [3:0]        b_be = '0;
  logic [DATA_W-1:0] b_wdata = '0;

  logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_bm, sram_din, sram_dout;
  logic              men, wen, ren;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic              port;
    logic [DATA_W-1:0] data;
  } sb_t;
  sb_t sb_q[$];

  logic [DATA_W-1:0] exp_mem [1024];
  logic [DATA_W-1:0] mem [1024];

  always #5 clk = ~clk;

  sram_arbiter_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_be_i(a_be),
    .a_wdata_i(a_wdata), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_be_i(b_be),
    .b_wdata_i(b_wdata), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .sram_addr_o(sram_addr), .sram_bm_o(sram_bm), .sram_din_o(sram_din),
    .sram_men_o(men), .sram_wen_o(wen), .sram_ren_o(ren), .sram_dout_i(sram_dout)
  );

  // Behavioural macro: masked write, read data appears the cycle after REN.
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    sram_dout = '0;
  end

  always @(posedge clk) begin
    if (men === 1'b1) begin
      if (wen === 1'b1) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
      if (ren === 1'b1) sram_dout <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and RVALID exclusivity
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("rvalid_excl", {31'b0, (a_rvalid === 1'b1) && (b_rvalid === 1'b1)}, 32'd0);
      if (a_rvalid === 1'b1 || b_rvalid === 1'b1) begin
        chk("sb_nonempty", {31'b0, sb_q.size() > 0}, 32'd1);
        if (sb_q.size() > 0) begin
          sb_t e;
          e = sb_q.pop_front();
          chk("sb_port", {31'b0, b_rvalid === 1'b1}, {31'b0, e.port});
          chk("sb_data", (b_rvalid === 1'b1) ? b_rdata : a_rdata, e.data);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge of the CMD cycle.
  task automatic do_cmd(input bit port, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [3:0] be, input logic [DATA_W-1:0] wd, input bit push);
    int n;
    logic [DATA_W-1:0] m;
    if (!port) begin
      a_req = 1; a_we = we; a_addr = addr; a_be = be; a_wdata = wd;
    end else begin
      b_req = 1; b_we = we; b_addr = addr; b_be = be; b_wdata = wd;
    end
    #1;
    n = 0;
    while (((port ? b_gnt : a_gnt) !== 1'b1) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    assert (n < 20) else begin
      errors++;
      $error("FAIL gnt_timeout port=%0d: observed no grant expected grant within 20 cycles", port);
    end
    if (we) begin
      m = '0;
      for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
      exp_mem[addr] = (exp_mem[addr] & ~m) | (wd & m);
    end else if (push) begin
      sb_q.push_back({port, exp_mem[addr]});
    end
    @(negedge clk);
    a_req = 0; b_req = 0;
  endtask

  // Read with full timing checks; returns at the negedge of the RVALID cycle.
  task automatic read_check(input bit port, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] expv);
    do_cmd(port, 0, addr, 4'h0, '0, 1);
    chk("rd_men", {31'b0, men}, 32'd1);
    chk("rd_ren", {31'b0, ren}, 32'd1);
    chk("rd_wen", {31'b0, wen}, 32'd0);
    chk("rd_addr", {22'b0, sram_addr}, {22'b0, addr});
    chk("rd_bm", sram_bm, 32'd0);
    chk("rd_din", sram_din, 32'd0);
    @(negedge clk);
    chk("rd_men_t2", {31'b0, men}, 32'd0);
    chk("rd_rvalid_t2", {31'b0, port ? b_rvalid : a_rvalid}, 32'd0);
    @(negedge clk);
    chk("rd_rvalid_t3", {31'b0, port ? b_rvalid : a_rvalid}, 32'd1);
    chk("rd_other_rvalid_t3", {31'b0, port ? a_rvalid : b_rvalid}, 32'd0);
    chk("rd_rdata", port ? b_rdata : a_rdata, expv);
  endtask

  task automatic pulse_reset();
    a_req = 0; b_req = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_a_gnt", {31'b0, a_gnt}, 32'd0);
    chk("rst_b_gnt", {31'b0, b_gnt}, 32'd0);
    chk("rst_a_rvalid", {31'b0, a_rvalid}, 32'd0);
    chk("rst_b_rvalid", {31'b0, b_rvalid}, 32'd0);
    chk("rst_strobes", {29'b0, men, wen, ren}, 32'd0);
    chk("rst_addr", {22'b0, sram_addr}, 32'd0);
    chk("rst_bm", sram_bm, 32'd0);
    chk("rst_din", sram_din, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    rst = 0;

    // Full write then readback on A
    do_cmd(0, 1, 10'h3FF, 4'hF, 32'hDEADBEEF, 0);
    chk("wr_men", {31'b0, men}, 32'd1);
    chk("wr_wen", {31'b0, wen}, 32'd1);
    chk("wr_ren", {31'b0, ren}, 32'd0);
    chk("wr_addr", {22'b0, sram_addr}, 32'h3FF);
    chk("wr_bm", sram_bm, 32'hFFFFFFFF);
    chk("wr_din", sram_din, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_men_after", {31'b0, men}, 32'd0);
    chk("wr_addr_hold", {22'b0, sram_addr}, 32'h3FF);
    read_check(0, 10'h3FF, 32'hDEADBEEF);

    // Byte-masked write via B
    do_cmd(1, 1, 10'h010, 4'hF, 32'h00000000, 0);
    do_cmd(1, 1, 10'h010, 4'b0101, 32'hAABBCCDD, 0);
    chk("be_bm", sram_bm, 32'h00FF00FF);
    chk("be_din", sram_din, 32'hAABBCCDD);
    @(negedge clk);
    read_check(1, 10'h010, 32'h00BB00DD);

    // Round-robin from reset with continuous simultaneous reads
    do_cmd(0, 1, 10'h001, 4'hF, 32'h11111111, 0);
    do_cmd(1, 1, 10'h002, 4'hF, 32'h22222222, 0);
    @(negedge clk);
    pulse_reset();
    a_req = 1; a_we = 0; a_addr = 10'h001;
    b_req = 1; b_we = 0; b_addr = 10'h002;
    #1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      if (a_gnt === 1'b1 || b_gnt === 1'b1) begin
        chk("rr_one_gnt", {31'b0, (a_gnt === 1'b1) && (b_gnt === 1'b1)}, 32'd0);
        chk("rr_order", {31'b0, b_gnt}, (ng % 2 == 0) ? 32'd0 : 32'd1);
        sb_q.push_back({b_gnt, b_gnt ? exp_mem[2] : exp_mem[1]});
        ng++;
      end
      @(negedge clk); #1;
    end
    a_req = 0; b_req = 0;
    chk("rr_grants", ng, 32'd4);
    repeat (4) @(negedge clk);
    chk("rr_sb_drained", sb_q.size(), 32'd0);

    // Write with BE=0 leaves the word untouched
    do_cmd(0, 1, 10'h020, 4'hF, 32'h12345678, 0);
    do_cmd(1, 1, 10'h020, 4'h0, 32'hFFFFFFFF, 0);
    chk("be0_men", {31'b0, men}, 32'd1);
    chk("be0_wen", {31'b0, wen}, 32'd1);
    chk("be0_bm", sram_bm, 32'd0);
    @(negedge clk);
    chk("be0_men_after", {31'b0, men}, 32'd0);
    read_check(0, 10'h020, 32'h12345678);

    // Reset during RWAIT of an A read; pointer was left at B by that grant
    do_cmd(0, 0, 10'h3FF, 4'h0, '0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mrst_a_rvalid", {31'b0, a_rvalid}, 32'd0);
    chk("mrst_strobes", {29'b0, men, wen, ren}, 32'd0);
    chk("mrst_a_rdata", a_rdata, 32'd0);
    rst = 0;
    a_req = 1; a_we = 0; a_addr = 10'h001;
    b_req = 1; b_we = 0; b_addr = 10'h002;
    #1;
    chk("mrst_a_gnt", {31'b0, a_gnt}, 32'd1);
    chk("mrst_b_gnt", {31'b0, b_gnt}, 32'd0);
    if (a_gnt === 1'b1) sb_q.push_back({1'b0, exp_mem[1]});
    @(negedge clk);
    a_req = 0; b_req = 0;
    repeat (4) @(negedge clk);

    // Back-to-back writes from A alone
    a_req = 1; a_we = 1; a_addr = 10'h040; a_be = 4'hF; a_wdata = 32'h5555AAAA;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bb_gnt", {31'b0, a_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("bb_men", {31'b0, men}, (i % 2 == 1) ? 32'd1 : 32'd0);
      @(negedge clk); #1;
    end
    a_req = 0;
    exp_mem[10'h040] = 32'h5555AAAA;
    @(negedge clk);
    read_check(1, 10'h040, 32'h5555AAAA);

    repeat (4) @(negedge clk);
    chk("sb_empty_end", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
